pe_array_pipe: RTL and testbench

//   P-lane pipelined successor of the scalar f/g processing element for the SC polar decoder.

---
 rtl/pe_array_pipe.sv | 136 +++++++++++++
 tb/tb_pe_array_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_pipe.sv
// pe_array_pipe: P-lane pipelined f/g processing element for the SC polar decoder.
// Two register stages under a valid/ready handshake; mode and tag are shared by all lanes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    input beat handshake
//   flag                  1 = f (min-sum), 0 = g, for all lanes
//   s                     per-lane partial sum bit for g
//   llr_a, llr_b          lane i at [i*LLR_W +: LLR_W]
//   tag_in                sideband carried with the beat
//   out_valid, out_ready  output beat handshake
//   dout                  lane results, same packing as the inputs
//   tag_out               tag of the beat currently on dout
module pe_array_pipe #(
   parameter int LLR_W   = 6,
   parameter int P       = 4,
   parameter int OFFSET  = 0,
   parameter int SYM_SAT = 1,
   parameter int TAG_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flag,
   input  logic [P-1:0]       s,
   input  logic [P*LLR_W-1:0] llr_a,
   input  logic [P*LLR_W-1:0] llr_b,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P*LLR_W-1:0] dout,
   output logic [TAG_W-1:0]   tag_out
);

   localparam int W = LLR_W;

   // Saturation bounds held in W+1 bits so they compare directly with the g sum.
   localparam logic signed [W:0] HI = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0] LO = (SYM_SAT != 0) ?
      {2'b11, {(W-2){1'b0}}, 1'b1} : {2'b11, {(W-1){1'b0}}};
   localparam logic [W-1:0] OFS = W'(OFFSET);

   // |x| never wraps: the most negative code maps to +M.
   function automatic logic [W-1:0] sat_abs(input logic [W-1:0] x);
      if (x[W-1]) begin
         if (x == {1'b1, {(W-1){1'b0}}}) return HI[W-1:0];
         return -x;
      end
      return x;
   endfunction

   // Stage 1
   logic               s1_valid_q;
   logic               s1_flag_q;
   logic [TAG_W-1:0]   s1_tag_q;
   logic [P-1:0]       s1_sgn_q,  s1_sgn_d;
   logic [W-1:0]       s1_absa_q [P];
   logic [W-1:0]       s1_absa_d [P];
   logic [W-1:0]       s1_absb_q [P];
   logic [W-1:0]       s1_absb_d [P];
   logic [W:0]         s1_sum_q  [P];
   logic [W:0]         s1_sum_d  [P];

   // Stage 2
   logic               out_valid_q;
   logic [P*W-1:0]     dout_q, dout_d;
   logic [TAG_W-1:0]   tag_q;

   logic adv1, adv2;

   // out_ready reaches in_ready combinationally so a full pipe can stream.
   assign adv2     = ~out_valid_q | out_ready;
   assign adv1     = ~s1_valid_q | adv2;
   assign in_ready = adv1 & ~rst;

   for (genvar i = 0; i < P; i++) begin : g_lane
      logic [W-1:0]      a_w, b_w;
      logic signed [W:0] ax, bx, t;
      logic [W-1:0]      mn, m, fv, gv;

      assign a_w = llr_a[i*W +: W];
      assign b_w = llr_b[i*W +: W];
      assign ax  = {a_w[W-1], a_w};
      assign bx  = {b_w[W-1], b_w};

      assign s1_absa_d[i] = sat_abs(a_w);
      assign s1_absb_d[i] = sat_abs(b_w);
      assign s1_sgn_d[i]  = a_w[W-1] ^ b_w[W-1];
      assign s1_sum_d[i]  = s[i] ? bx - ax : bx + ax;

      assign mn = (s1_absa_q[i] < s1_absb_q[i]) ?
                  s1_absa_q[i] : s1_absb_q[i];
      assign m  = (mn > OFS) ? mn - OFS : '0;
      assign fv = s1_sgn_q[i] ? -m : m;

      assign t  = s1_sum_q[i];
      assign gv = (t > HI) ? HI[W-1:0] :
                  (t < LO) ? LO[W-1:0] : t[W-1:0];

      assign dout_d[i*W +: W] = s1_flag_q ? fv : gv;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         tag_q       <= '0;
      end else begin
         if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_flag_q <= flag;
               s1_tag_q  <= tag_in;
               s1_sgn_q  <= s1_sgn_d;
               s1_absa_q <= s1_absa_d;
               s1_absb_q <= s1_absb_d;
               s1_sum_q  <= s1_sum_d;
            end
         end
         if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               dout_q <= dout_d;
               tag_q  <= s1_tag_q;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign tag_out   = tag_q;

endmodule

// File: tb/tb_pe_array_pipe.sv
// tb_pe_array_pipe: directed vectors for pe_array_pipe in three configurations
// (default, SYM_SAT=0, OFFSET=1), plus backpressure, throughput and reset sequences.
module tb_pe_array_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        flag = 1'b0;
   logic [3:0]  s = '0;
   logic [23:0] llr_a = '0;
   logic [23:0] llr_b = '0;
   logic [3:0]  tag_in = '0;
   logic        out_ready = 1'b1;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [23:0] dout0, dout1, dout2;
   logic [3:0]  tag_out0, tag_out1, tag_out2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pe_array_pipe dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .flag(flag), .s(s), .llr_a(llr_a), .llr_b(llr_b), .tag_in(tag_in),
      .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0),
      .tag_out(tag_out0));

   pe_array_pipe #(.SYM_SAT(0)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .flag(flag), .s(s), .llr_a(llr_a), .llr_b(llr_b), .tag_in(tag_in),
      .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1),
      .tag_out(tag_out1));

   pe_array_pipe #(.OFFSET(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .flag(flag), .s(s), .llr_a(llr_a), .llr_b(llr_b), .tag_in(tag_in),
      .out_valid(out_valid2), .out_ready(out_ready), .dout(dout2),
      .tag_out(tag_out2));

   typedef struct packed {
      logic [1:0]  sel;
      logic        fl;
      logic [3:0]  sv;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] e;
   } vec_t;

   vec_t tbl [9];

   function automatic logic [23:0] pk(input int x0, input int x1,
                                      input int x2, input int x3);
      return {x3[5:0], x2[5:0], x1[5:0], x0[5:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic run_stream(input int n, input int st_lo, input int st_hi,
                             output int first_acc, output int first_val,
                             output int max_run, output int irdy_low,
                             output int recv);
      logic [23:0] qd [$];
      logic [3:0]  qt [$];
      int sent = 0;
      int run = 0;
      first_acc = -1;
      first_val = -1;
      max_run = 0;
      irdy_low = 0;
      recv = 0;
      for (int cyc = 0; cyc < 80 && recv < n; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= st_lo && cyc <= st_hi);
         if (sent < n) begin
            in_valid = 1'b1;
            flag = 1'b0;
            s = 4'b0000;
            llr_a = pk(sent, sent, sent, sent);
            llr_b = pk(0, 1, 2, 3);
            tag_in = sent[3:0];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid0) begin
            run++;
            if (run > max_run) max_run = run;
            if (first_val < 0) first_val = cyc;
            if (qd.size() == 0) begin
               chk("stream spurious out_valid", 32'd1, 32'd0);
            end else begin
               chk($sformatf("stream dout c%0d", cyc), dout0, qd[0]);
               chk($sformatf("stream tag c%0d", cyc), tag_out0, qt[0]);
               if (out_ready) begin
                  void'(qd.pop_front());
                  void'(qt.pop_front());
                  recv++;
               end
            end
         end else begin
            run = 0;
         end
         if (in_valid && !in_ready0) irdy_low++;
         if (in_valid && in_ready0) begin
            qd.push_back(pk(sent, sent + 1, sent + 2, sent + 3));
            qt.push_back(sent[3:0]);
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fa, fv, mr, il, rc;

      tbl[0] = '{2'd0, 1'b1, 4'b0000, pk(5, -32, 0, -9),
                 pk(-3, -32, -7, -12), pk(-3, 31, 0, 9)};
      tbl[1] = '{2'd0, 1'b0, 4'b1010, pk(20, 20, -3, 7),
                 pk(20, -20, 4, 7), pk(31, -31, 1, 0)};
      tbl[2] = '{2'd1, 1'b0, 4'b1010, pk(20, 20, -3, 7),
                 pk(20, -20, 4, 7), pk(31, -32, 1, 0)};
      tbl[3] = '{2'd2, 1'b1, 4'b0000, pk(1, -4, -5, 0),
                 pk(7, 6, -5, 3), pk(0, -3, 4, 0)};
      tbl[4] = '{2'd0, 1'b0, 4'b1010, pk(-32, -32, -32, 31),
                 pk(-32, 31, 31, -32), pk(-31, 31, -1, -31)};
      tbl[5] = '{2'd1, 1'b0, 4'b1010, pk(-32, -32, -32, 31),
                 pk(-32, 31, 31, -32), pk(-32, 31, -1, -32)};
      tbl[6] = '{2'd0, 1'b1, 4'b1111, pk(-1, 31, 12, -31),
                 pk(2, -32, -12, -31), pk(-1, -31, -12, 31)};
      tbl[7] = '{2'd1, 1'b1, 4'b0000, pk(-32, 5, -6, 0),
                 pk(-32, -32, -32, 0), pk(31, -5, 6, 0)};
      tbl[8] = '{2'd2, 1'b0, 4'b1010, pk(3, -10, 0, 15),
                 pk(4, 2, 0, -16), pk(7, 12, 0, -31)};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", out_valid0, 0);
      chk("reset dout", dout0, 0);
      chk("reset tag_out", tag_out0, 0);
      chk("reset in_ready", in_ready0, 0);
      rst = 1'b0;
      #1 chk("in_ready after reset", in_ready0, 1);

      // Directed vectors
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         flag = tbl[k].fl;
         s = tbl[k].sv;
         llr_a = tbl[k].a;
         llr_b = tbl[k].b;
         tag_in = k[3:0];
         in_valid = 1'b1;
         #1 chk($sformatf("vec%0d in_ready", k), in_ready0, 1);
         @(posedge clk);
         #1 in_valid = 1'b0;
         chk($sformatf("vec%0d early valid", k), out_valid0, 0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", k), out_valid0, 1);
         chk($sformatf("vec%0d tag", k), tag_out0, k);
         unique case (tbl[k].sel)
            2'd0:    chk($sformatf("vec%0d dout", k), dout0, tbl[k].e);
            2'd1:    chk($sformatf("vec%0d dout symsat0", k), dout1, tbl[k].e);
            default: chk($sformatf("vec%0d dout offset1", k), dout2, tbl[k].e);
         endcase
      end

      // Backpressure: stall cycles 3..6
      repeat (2) @(negedge clk);
      run_stream(6, 3, 6, fa, fv, mr, il, rc);
      chk("bp received", rc, 6);
      chk("bp in_ready low cycles", il, 4);
      chk("bp first out", fv, 2);

      // Throughput
      repeat (2) @(negedge clk);
      run_stream(16, -1, -1, fa, fv, mr, il, rc);
      chk("tp received", rc, 16);
      chk("tp latency", fv - fa, 2);
      chk("tp consecutive valid", mr, 16);
      chk("tp in_ready stalls", il, 0);

      // Reset with two beats in flight
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      flag = 1'b1;
      s = 4'b0000;
      llr_a = pk(3, 3, 3, 3);
      llr_b = pk(3, 3, 3, 3);
      tag_in = 4'd9;
      in_valid = 1'b1;
      @(negedge clk);
      tag_in = 4'd10;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1 chk("rst in_ready", in_ready0, 0);
      chk("pre-rst out_valid", out_valid0, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst out_valid", out_valid0, 0);
      chk("post-rst dout", dout0, 0);
      chk("post-rst tag", tag_out0, 0);
      chk("post-rst in_ready", in_ready0, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk($sformatf("flushed beat c%0d", k), out_valid0, 0);
      end
      @(negedge clk);
      flag = 1'b0;
      s = 4'b0101;
      llr_a = pk(1, 2, 3, 4);
      llr_b = pk(5, 6, 7, 8);
      tag_in = 4'd12;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("fresh out_valid", out_valid0, 1);
      chk("fresh dout", dout0, pk(4, 8, 4, 12));
      chk("fresh tag", tag_out0, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
